dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-master arbiter that shares the single data-memory port between the pipeline M stage (master 0) and a secondary bus master such as a debug/DMA loader (master 1). It grants at most one access per cycle with round-robin fairness. It drives the memory's write-enable, load/store-select, address, data and PC lines, and returns registered read data with a one-cycle valid pulse. It also rejects misaligned or out-of-range accesses with an error pulse instead of forwarding them.

## Interface
- `MEM_WORDS`, default 1024: memory depth in words; word index `addr[31:2] >= MEM_WORDS` is out of range.
- `clk` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-high reset.
- `m0_req`, `m1_req` in, 1: access request; held with stable payload until granted.
- `m0_we`, `m1_we` in, 1: 1 = store, 0 = load.
- `m0_lds`, `m1_lds` in, 2: load select; 01 = byte sign-extended, else word.
- `m0_sds`, `m1_sds` in, 2: store select; 01 = byte, else word.
- `m0_addr`, `m1_addr` in, 32: byte address.
- `m0_wdata`, `m1_wdata` in, 32: store data.
- `m0_pc`, `m1_pc` in, 32: PC tag for the memory's write log.
- `m0_lock`, `m1_lock` in, 1: hold grant across back-to-back requests. Only active with `DM_ARB_LOCK_EN`.
- `m0_gnt`, `m1_gnt` out, 1: combinational grant; the access completes at the next rising edge.
- `m0_rvalid`, `m1_rvalid` out, 1: registered one-cycle pulse; read data valid.
- `m0_rdata`, `m1_rdata` out, 32: registered load data; holds until the next read by that master.
- `m0_err`, `m1_err` out, 1: registered one-cycle pulse; the access was rejected.
- `dm_we` out, 1: memory write enable.
- `dm_lds`, `dm_sds` out, 2: forwarded load/store selects.
- `dm_addr`, `dm_din`, `dm_pc` out, 32: forwarded address, data and PC.
- `dm_dout` in, 32: combinational read data from memory.

## Operation
- **Priority pointer `last`** (1 bit): records the master granted most recently; reset value 1, so master 0 wins the first conflict.
- **Single request:** the requester is granted in the same cycle.
- **Both requesting:** the master that is not `last` is granted. `last` updates at the edge whenever a grant occurs.
- **Mux:** the granted master's payload drives all `dm_*` outputs. With no grant, `dm_*` outputs are 0 and `dm_we = 0`.
- **Rejection:**
  - A word access (`sds/lds != 01`) with `addr[1:0] != 00` is rejected.
  - Any access with `addr[31:2] >= MEM_WORDS` is rejected.
  - A rejected access is still granted, which consumes the slot and updates `last`, but `dm_we = 0`.
  - The corresponding `err` pulses next cycle and `rvalid` stays 0.
- **Load:** at the granting edge, `dm_dout` is captured into that master's `rdata`, and `rvalid` pulses for exactly one cycle.
- **Store:** `dm_we = we & ~reject`. No `rvalid` pulse is generated.
- A non-granted master keeps `req` high. Dropping `req` before grant withdraws the request with no side effects.
- **Reset (asynchronous, takes effect immediately):**
  - `last = 1`; all `rvalid` and `err` = 0; all `rdata` = 0.
  - An in-flight read is lost, and no pulse appears after reset releases.
- **Reset-state outputs:** while reset is high, `gnt` and `dm_we` are forced to 0.

## Timing
- Grant-to-memory latency is 0 cycles (combinational path `req` → `gnt` → `dm_*`). The store commits at the first rising edge with `gnt`.
- Load latency: request granted in cycle N, `rvalid`/`rdata` valid in cycle N+1.
- Throughput is one access per cycle in total. Under continuous contention the masters alternate, giving each one access every 2 cycles.
- `rvalid` and `err` for the same master are never high together.

## Configuration
- **`DM_ARB_LOCK_EN` defined:** a lock register `owner_locked` plus owner ID is added.
  - It is set at a granting edge where the granted master's `lock = 1`.
  - It is cleared at the first edge where the owner's `lock = 0`, or on reset.
  - While set, only the owner can be granted; the other master waits regardless of `last`. `last` is not updated during locked grants.
- **`DM_ARB_LOCK_EN` undefined:** the `lock` ports are present but ignored, and arbitration is pure round-robin.

## Test plan
- **Reset state:** assert `reset` mid-cycle → all `gnt`, `rvalid`, `err` and `dm_we` are 0 immediately. After release, both masters request → `m0_gnt = 1`.
- **Contended loads:** `mem[4] = 32'h12345678`. Both masters load word at `0x10` in every cycle for 4 cycles → grants alternate m0, m1, m0, m1. Each `rvalid` pulse carries `32'h12345678` one cycle after its grant.
- **Byte store:** m1 byte-stores `32'h000000AB` to `0x21` while m0 is idle → `dm_we = 1`, `dm_sds = 01`, `dm_addr = 0x21`. A later m0 byte load at `0x21` returns `32'hFFFFFFAB`.
- **Misaligned word:** m0 word-stores to `0x22` → `gnt = 1`, `dm_we = 0`, `m0_err` pulses next cycle, and memory is unchanged.
- **Out of range:** m1 loads `0x00001000` with `MEM_WORDS = 1024` → `m1_err` pulses and `m1_rvalid` stays 0.
- **Lock (with `DM_ARB_LOCK_EN`):** m0 holds `lock = 1` for 3 grants while m1 requests continuously → m1 is not granted until the cycle after `m0_lock` drops. Without the macro, grants alternate.

Source files
------------

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the data-memory port between the M stage (m0) and a bus master (m1).
// Rejects misaligned word and out-of-range accesses; define DM_ARB_LOCK_EN to enable grant locking.
module dm_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [1:0]  m0_lds,
  input  logic [1:0]  m1_lds,
  input  logic [1:0]  m0_sds,
  input  logic [1:0]  m1_sds,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  input  logic [31:0] m0_pc,
  input  logic [31:0] m1_pc,
  input  logic        m0_lock,
  input  logic        m1_lock,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_rvalid,
  output logic        m1_rvalid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic        m0_err,
  output logic        m1_err,
  output logic        dm_we,
  output logic [1:0]  dm_lds,
  output logic [1:0]  dm_sds,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_din,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_dout
);

  localparam logic [31:0] MemWordsW = 32'(MEM_WORDS);

  // Handshake: a master holds req with a stable payload; gnt is combinational and the
  // access completes at the next rising edge. Dropping req before gnt withdraws it.

  // Word accesses (select != 01) must be aligned; any access must fall inside the memory.
  function automatic logic access_reject(input logic        we,
                                         input logic [1:0]  lds,
                                         input logic [1:0]  sds,
                                         input logic [31:0] addr);
    logic word_acc;
    word_acc = we ? (sds != 2'b01) : (lds != 2'b01);
    return (word_acc && (addr[1:0] != 2'b00)) || ({2'b00, addr[31:2]} >= MemWordsW);
  endfunction

  logic        last_q, last_d;
  logic        m0_rvalid_q, m0_rvalid_d;
  logic        m1_rvalid_q, m1_rvalid_d;
  logic        m0_err_q, m0_err_d;
  logic        m1_err_q, m1_err_d;
  logic [31:0] m0_rdata_q, m0_rdata_d;
  logic [31:0] m1_rdata_q, m1_rdata_d;
  logic        gnt0, gnt1;
  logic        rej0, rej1;
  logic        locked_grant;

  assign rej0 = access_reject(m0_we, m0_lds, m0_sds, m0_addr);
  assign rej1 = access_reject(m1_we, m1_lds, m1_sds, m1_addr);

`ifdef DM_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic owner_q, owner_d;

  assign locked_grant = locked_q;

  always_comb begin
    locked_d = locked_q;
    owner_d  = owner_q;
    if (locked_q) begin
      if (!(owner_q ? m1_lock : m0_lock)) locked_d = 1'b0;
    end else if (gnt0 && m0_lock) begin
      locked_d = 1'b1;
      owner_d  = 1'b0;
    end else if (gnt1 && m1_lock) begin
      locked_d = 1'b1;
      owner_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      locked_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      locked_q <= locked_d;
      owner_q  <= owner_d;
    end
  end

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (locked_q) begin
      gnt0 = !owner_q && m0_req;
      gnt1 = owner_q && m1_req;
    end else begin
      gnt0 = m0_req && (!m1_req || last_q);
      gnt1 = m1_req && (!m0_req || !last_q);
    end
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock  = m0_lock ^ m1_lock;
  assign locked_grant = 1'b0;

  // On conflict the master that did not win last time is served.
  always_comb begin
    gnt0 = m0_req && (!m1_req || last_q);
    gnt1 = m1_req && (!m0_req || !last_q);
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end
`endif

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    dm_we   = 1'b0;
    dm_lds  = 2'b00;
    dm_sds  = 2'b00;
    dm_addr = 32'd0;
    dm_din  = 32'd0;
    dm_pc   = 32'd0;
    if (gnt0) begin
      dm_we   = m0_we && !rej0;
      dm_lds  = m0_lds;
      dm_sds  = m0_sds;
      dm_addr = m0_addr;
      dm_din  = m0_wdata;
      dm_pc   = m0_pc;
    end else if (gnt1) begin
      dm_we   = m1_we && !rej1;
      dm_lds  = m1_lds;
      dm_sds  = m1_sds;
      dm_addr = m1_addr;
      dm_din  = m1_wdata;
      dm_pc   = m1_pc;
    end
  end

  always_comb begin
    last_d = last_q;
    if ((gnt0 || gnt1) && !locked_grant) last_d = gnt1;
    m0_rvalid_d = gnt0 && !rej0 && !m0_we;
    m1_rvalid_d = gnt1 && !rej1 && !m1_we;
    m0_err_d    = gnt0 && rej0;
    m1_err_d    = gnt1 && rej1;
    m0_rdata_d  = m0_rvalid_d ? dm_dout : m0_rdata_q;
    m1_rdata_d  = m1_rvalid_d ? dm_dout : m1_rdata_q;
  end

  // Reset value of last is 1 so that m0 wins the first conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q      <= 1'b1;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= 32'd0;
      m1_rdata_q  <= 32'd0;
    end else begin
      last_q      <= last_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_err_q    <= m0_err_d;
      m1_err_q    <= m1_err_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic against a behavioural model
// of arbitration, rejection and a word-addressed memory image.
module tb_dm_arbiter;
  localparam int MEM_WORDS = 1024;
`ifdef DM_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        d_req [2];
  logic        d_we [2];
  logic        d_lock [2];
  logic [1:0]  d_lds [2];
  logic [1:0]  d_sds [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_pc [2];

  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        dm_we;
  logic [1:0]  dm_lds, dm_sds;
  logic [31:0] dm_addr, dm_din, dm_pc, dm_dout;

  dm_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .m0_req(d_req[0]), .m1_req(d_req[1]),
    .m0_we(d_we[0]), .m1_we(d_we[1]),
    .m0_lds(d_lds[0]), .m1_lds(d_lds[1]),
    .m0_sds(d_sds[0]), .m1_sds(d_sds[1]),
    .m0_addr(d_addr[0]), .m1_addr(d_addr[1]),
    .m0_wdata(d_wdata[0]), .m1_wdata(d_wdata[1]),
    .m0_pc(d_pc[0]), .m1_pc(d_pc[1]),
    .m0_lock(d_lock[0]), .m1_lock(d_lock[1]),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_err(m0_err), .m1_err(m1_err),
    .dm_we(dm_we), .dm_lds(dm_lds), .dm_sds(dm_sds),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_pc(dm_pc), .dm_dout(dm_dout)
  );

  // data memory attached to the dm_* port
  logic [31:0] mem [MEM_WORDS];
  logic        env_clear, env_wr;
  logic [9:0]  env_idx;
  logic [31:0] env_val;
  logic [31:0] env_word;
  logic [7:0]  env_byte;

  assign env_word = mem[dm_addr[11:2]];
  assign env_byte = 8'(env_word >> {dm_addr[1:0], 3'b000});
  assign dm_dout  = (dm_lds == 2'b01) ? {{24{env_byte[7]}}, env_byte} : env_word;

  always @(posedge clk) begin
    if (env_clear) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 32'd0;
    end else if (env_wr) begin
      mem[env_idx] <= env_val;
    end else if (dm_we) begin
      if (dm_sds == 2'b01) mem[dm_addr[11:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
      else mem[dm_addr[11:2]] <= dm_din;
    end
  end

  // reference model
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_last, m_owner, mw;
  bit          m_locked, m_rej;
  logic [31:0] exp_mem [MEM_WORDS];
  logic        exp_gnt [2];
  logic        exp_rvalid [2];
  logic        exp_err [2];
  logic [31:0] exp_rdata [2];
  logic [100:0] exp_bus, act_bus;

  assign act_bus = {dm_we, dm_lds, dm_sds, dm_addr, dm_din, dm_pc};

  function automatic bit is_rejected(input logic we, input logic [1:0] lds, input logic [1:0] sds,
                                     input logic [31:0] a);
    bit word_acc;
    word_acc = we ? (sds != 2'b01) : (lds != 2'b01);
    return (word_acc && (a % 4 != 0)) || ((a / 4) >= 32'(MEM_WORDS));
  endfunction

  function automatic logic [31:0] load_value(input logic [31:0] a, input logic [1:0] lds);
    logic [31:0] w;
    logic [7:0]  b;
    w = exp_mem[int'(a / 4)];
    if (lds != 2'b01) return w;
    b = 8'(w >> (8 * int'(a % 4)));
    return {{24{b[7]}}, b};
  endfunction

  task automatic model_reset();
    m_last   = 1;
    m_locked = 1'b0;
    m_owner  = 0;
    for (int m = 0; m < 2; m++) begin
      exp_rvalid[m] = 1'b0;
      exp_err[m]    = 1'b0;
      exp_rdata[m]  = 32'd0;
    end
  endtask

  task automatic model_predict();
    mw = -1;
    if (LOCK_EN && m_locked) begin
      if (d_req[m_owner]) mw = m_owner;
    end else if (d_req[0] && d_req[1]) mw = 1 - m_last;
    else if (d_req[0]) mw = 0;
    else if (d_req[1]) mw = 1;
    exp_gnt[0] = (mw == 0);
    exp_gnt[1] = (mw == 1);
    m_rej   = 1'b0;
    exp_bus = '0;
    if (mw >= 0) begin
      m_rej   = is_rejected(d_we[mw], d_lds[mw], d_sds[mw], d_addr[mw]);
      exp_bus = {d_we[mw] & ~m_rej, d_lds[mw], d_sds[mw], d_addr[mw], d_wdata[mw], d_pc[mw]};
    end
  endtask

  task automatic model_commit();
    bit was_locked;
    int idx, sh;
    was_locked = LOCK_EN && m_locked;
    for (int m = 0; m < 2; m++) begin
      exp_rvalid[m] = 1'b0;
      exp_err[m]    = 1'b0;
    end
    if (mw >= 0) begin
      if (!was_locked) m_last = mw;
      if (m_rej) exp_err[mw] = 1'b1;
      else if (d_we[mw]) begin
        idx = int'(d_addr[mw] / 4);
        if (d_sds[mw] == 2'b01) begin
          sh = 8 * int'(d_addr[mw] % 4);
          exp_mem[idx] = (exp_mem[idx] & ~(32'hFF << sh)) | ({24'd0, d_wdata[mw][7:0]} << sh);
        end else exp_mem[idx] = d_wdata[mw];
      end else begin
        exp_rvalid[mw] = 1'b1;
        exp_rdata[mw]  = load_value(d_addr[mw], d_lds[mw]);
      end
    end
    if (LOCK_EN) begin
      if (m_locked) begin
        if (!d_lock[m_owner]) m_locked = 1'b0;
      end else if (mw >= 0 && d_lock[mw]) begin
        m_locked = 1'b1;
        m_owner  = mw;
      end
    end
  endtask

  // driver tasks
  task automatic idle_all();
    for (int m = 0; m < 2; m++) begin
      d_req[m] = 1'b0; d_we[m] = 1'b0; d_lock[m] = 1'b0;
      d_lds[m] = 2'b00; d_sds[m] = 2'b00;
      d_addr[m] = 32'd0; d_wdata[m] = 32'd0; d_pc[m] = 32'd0;
    end
  endtask

  task automatic drive(input int m, input logic we, input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] wd, input logic lock);
    d_req[m] = 1'b1; d_we[m] = we; d_lds[m] = sel; d_sds[m] = sel;
    d_addr[m] = a; d_wdata[m] = wd; d_pc[m] = 32'h400 + 32'(m); d_lock[m] = lock;
  endtask

  task automatic apply_reset();
    idle_all();
    #1 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 2'b00, 32'h10, 32'h1, 1'b0);
    drive(1, 1'b1, 2'b00, 32'h10, 32'h2, 1'b0);
    #2;
    n_checks++; if ({m0_gnt, m1_gnt, dm_we} !== 3'b000) begin n_errors++; $display("FAIL reset_hold gnt/we got=%b exp=000", {m0_gnt, m1_gnt, dm_we}); end
    n_checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin n_errors++; $display("FAIL reset_hold pulses got=%b exp=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    d_we[0] = 1'b0; d_we[1] = 1'b0;
    reset = 1'b0; env_clear = 1'b0;
    model_reset();
    model_predict();
    #2;
    n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_errors++; $display("FAIL reset_first_conflict got=%b exp=10", {m0_gnt, m1_gnt}); end
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b10) begin n_errors++; $display("FAIL reset_first_load rvalid got=%b exp=10", {m0_rvalid, m1_rvalid}); end
    d_we[0] = 1'b1; d_we[1] = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_checks++; if ({m0_gnt, m1_gnt, dm_we} !== 3'b000) begin n_errors++; $display("FAIL reset_async gnt/we got=%b exp=000", {m0_gnt, m1_gnt, dm_we}); end
    n_checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin n_errors++; $display("FAIL reset_async pulses got=%b exp=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    idle_all();
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    n_checks++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0000) begin n_errors++; $display("FAIL reset_release pulses got=%b exp=0000", {m0_rvalid, m1_rvalid, m0_err, m1_err}); end
    n_checks++; if ({m0_rdata, m1_rdata} !== 64'd0) begin n_errors++; $display("FAIL reset_rdata got=%h exp=0", {m0_rdata, m1_rdata}); end
  endtask

  task automatic test_contended_loads();
    env_wr = 1'b1; env_idx = 10'd4; env_val = 32'h12345678;
    exp_mem[4] = 32'h12345678;
    @(posedge clk); #1;
    env_wr = 1'b0;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1'b0, 2'b00, 32'h10, 32'd0, 1'b0);
      drive(1, 1'b0, 2'b00, 32'h10, 32'd0, 1'b0);
      model_predict();
      #2;
      n_checks++; if ({m0_gnt, m1_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL contend_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      @(posedge clk); model_commit(); #1;
      n_checks++; if ({m0_rvalid, m1_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL contend_rvalid cyc=%0d got=%b", i, {m0_rvalid, m1_rvalid}); end
      n_checks++; if (((i % 2 == 0) ? m0_rdata : m1_rdata) !== 32'h12345678) begin n_errors++; $display("FAIL contend_rdata cyc=%0d got=%h exp=12345678", i, (i % 2 == 0) ? m0_rdata : m1_rdata); end
    end
    idle_all();
  endtask

  task automatic test_byte_store();
    idle_all();
    drive(1, 1'b1, 2'b01, 32'h21, 32'h000000AB, 1'b0);
    model_predict();
    #2;
    n_checks++; if ({m0_gnt, m1_gnt, dm_we, dm_sds} !== 5'b01101) begin n_errors++; $display("FAIL bstore_ctrl got=%b exp=01101", {m0_gnt, m1_gnt, dm_we, dm_sds}); end
    n_checks++; if ({dm_addr, dm_din} !== {32'h21, 32'hAB}) begin n_errors++; $display("FAIL bstore_addr_din got=%h exp=%h", {dm_addr, dm_din}, {32'h21, 32'hAB}); end
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m1_rvalid, m1_err} !== 2'b00) begin n_errors++; $display("FAIL bstore_no_pulse got=%b exp=00", {m1_rvalid, m1_err}); end
    idle_all();
    drive(0, 1'b0, 2'b01, 32'h21, 32'd0, 1'b0);
    model_predict();
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m0_rvalid, m0_rdata} !== {1'b1, 32'hFFFFFFAB}) begin n_errors++; $display("FAIL bload_rdata got=%b/%h exp=1/ffffffab", m0_rvalid, m0_rdata); end
    idle_all();
  endtask

  task automatic test_misaligned();
    drive(0, 1'b1, 2'b00, 32'h22, 32'hDEADBEEF, 1'b0);
    model_predict();
    #2;
    n_checks++; if ({m0_gnt, dm_we} !== 2'b10) begin n_errors++; $display("FAIL misalign_gnt_we got=%b exp=10", {m0_gnt, dm_we}); end
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m0_err, m0_rvalid} !== 2'b10) begin n_errors++; $display("FAIL misalign_err got=%b exp=10", {m0_err, m0_rvalid}); end
    drive(0, 1'b0, 2'b00, 32'h20, 32'd0, 1'b0);
    model_predict();
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m0_err, m0_rvalid} !== 2'b01) begin n_errors++; $display("FAIL misalign_err_pulse_end got=%b exp=01", {m0_err, m0_rvalid}); end
    n_checks++; if (m0_rdata !== 32'h0000AB00) begin n_errors++; $display("FAIL misalign_mem_intact got=%h exp=0000ab00", m0_rdata); end
    idle_all();
  endtask

  task automatic test_out_of_range();
    drive(1, 1'b0, 2'b00, 32'h00001000, 32'd0, 1'b0);
    model_predict();
    #2;
    n_checks++; if ({m1_gnt, dm_we} !== 2'b10) begin n_errors++; $display("FAIL oor_gnt_we got=%b exp=10", {m1_gnt, dm_we}); end
    @(posedge clk); model_commit(); #1;
    n_checks++; if ({m1_err, m1_rvalid} !== 2'b10) begin n_errors++; $display("FAIL oor_err got=%b exp=10", {m1_err, m1_rvalid}); end
    idle_all();
    model_predict();
    @(posedge clk); model_commit(); #1;
    n_checks++; if (m1_err !== 1'b0) begin n_errors++; $display("FAIL oor_err_pulse_end got=%b exp=0", m1_err); end
  endtask

  task automatic test_lock();
    logic [4:0] exp_g0, exp_g1;
    if (LOCK_EN) begin exp_g0 = 5'b00111; exp_g1 = 5'b10000; end
    else begin exp_g0 = 5'b00101; exp_g1 = 5'b11010; end
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) drive(0, 1'b0, 2'b00, 32'h10, 32'd0, 1'b1);
      else begin d_req[0] = 1'b0; d_lock[0] = 1'b0; end
      drive(1, 1'b0, 2'b00, 32'h10, 32'd0, 1'b0);
      model_predict();
      #2;
      n_checks++; if ({m0_gnt, m1_gnt} !== {exp_g0[i], exp_g1[i]}) begin n_errors++; $display("FAIL lock_gnt cyc=%0d got=%b exp=%b", i, {m0_gnt, m1_gnt}, {exp_g0[i], exp_g1[i]}); end
      @(posedge clk); model_commit(); #1;
    end
    idle_all();
    model_predict();
    @(posedge clk); model_commit(); #1;
  endtask

  task automatic test_random();
    bit granted [2];
    granted[0] = 1'b0; granted[1] = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        if (d_req[m] && !granted[m]) begin
          if ($urandom_range(0, 9) == 0) d_req[m] = 1'b0;
        end else begin
          d_req[m]   = ($urandom_range(0, 3) != 0);
          d_we[m]    = 1'($urandom_range(0, 1));
          d_lds[m]   = 2'($urandom_range(0, 2));
          d_sds[m]   = 2'($urandom_range(0, 2));
          case ($urandom_range(0, 7))
            0: d_addr[m] = 32'(MEM_WORDS * 4) + 32'($urandom_range(0, 255));
            1: d_addr[m] = 32'((MEM_WORDS - 1) * 4) + 32'($urandom_range(0, 3));
            2: d_addr[m] = $urandom;
            default: d_addr[m] = 32'($urandom_range(0, 63));
          endcase
          d_wdata[m] = $urandom;
          d_pc[m]    = $urandom;
          d_lock[m]  = ($urandom_range(0, 3) == 0);
        end
      end
      model_predict();
      granted[0] = exp_gnt[0];
      granted[1] = exp_gnt[1];
      #2;
      n_checks++; if ({m0_gnt, m1_gnt} !== {exp_gnt[0], exp_gnt[1]}) begin n_errors++; $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", cyc, {m0_gnt, m1_gnt}, {exp_gnt[0], exp_gnt[1]}); end
      n_checks++; if (act_bus !== exp_bus) begin n_errors++; $display("FAIL rand_dm_bus cyc=%0d got=%h exp=%h", cyc, act_bus, exp_bus); end
      @(posedge clk); model_commit(); #1;
      n_checks++; if ({m0_rvalid, m0_err, m1_rvalid, m1_err} !== {exp_rvalid[0], exp_err[0], exp_rvalid[1], exp_err[1]}) begin n_errors++; $display("FAIL rand_pulses cyc=%0d got=%b exp=%b", cyc, {m0_rvalid, m0_err, m1_rvalid, m1_err}, {exp_rvalid[0], exp_err[0], exp_rvalid[1], exp_err[1]}); end
      n_checks++; if ({m0_rdata, m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin n_errors++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, {m0_rdata, m1_rdata}, {exp_rdata[0], exp_rdata[1]}); end
    end
    idle_all();
  endtask

  initial begin
    reset = 1'b1;
    env_clear = 1'b1; env_wr = 1'b0; env_idx = 10'd0; env_val = 32'd0;
    idle_all();
    for (int i = 0; i < MEM_WORDS; i++) exp_mem[i] = 32'd0;
    model_reset();
    mw = -1; m_rej = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_contended_loads();
    test_byte_store();
    test_misaligned();
    test_out_of_range();
    test_lock();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
